// File: rtl/seq_array_mult.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Optional two's-complement support is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_array_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic [WIDTH-1:0] opa_s, opb_s;
  logic [PW-1:0]   addend_s, sum_s, final_s;

`ifdef SEQ_MULT_SIGNED_EN
  logic            neg_q, neg_d;
  logic            neg_s;

  // Signed operands are latched as magnitudes; the result sign is applied on entry to DONE.
  always_comb begin
    opa_s = a;
    opb_s = b;
    neg_s = 1'b0;
    if (sgn) begin
      if (a[WIDTH-1]) opa_s = ~a + WIDTH'(1);
      else            opa_s = a;
      if (b[WIDTH-1]) opb_s = ~b + WIDTH'(1);
      else            opb_s = b;
      neg_s = a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      neg_s = 1'b0;
    end
  end

  assign final_s = neg_q ? (~sum_s + PW'(1)) : sum_s;
`else
  logic            unused_s;

  assign unused_s = sgn;
  assign opa_s    = a;
  assign opb_s    = b;
  assign final_s  = sum_s;
`endif

  // The multiplicand register is pre-shifted each step, so it always equals a << step.
  assign addend_s = mplier_q[0] ? mcand_q : {PW{1'b0}};
  assign sum_s    = acc_q + addend_s;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d  = S_BUSY;
          mcand_d  = {{WIDTH{1'b0}}, opa_s};
          mplier_d = opb_s;
          acc_d    = {PW{1'b0}};
          cnt_d    = {CW{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
          neg_d    = neg_s;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        acc_d    = sum_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_C) begin
          state_d   = S_DONE;
          product_d = final_s;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= {PW{1'b0}};
      mplier_q  <= {WIDTH{1'b0}};
      acc_q     <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      product_q <= {PW{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_BUSY);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;

endmodule
